task_completion_collector: RTL and testbench
============================================

# task_completion_collector

Completion-side counterpart of the task scheduler: owns the per-core busy flags the scheduler reads, and collects finished tasks from the cores. Sets a core's busy flag when the scheduler dispatches to it. Accepts each core's done/result handshake with round-robin arbitration, buffers completions in a small FIFO, and presents them one at a time on a valid/ready completion port. Sits between the scheduler, the compute cores and the host/controller that retires tasks.

## Interface
- NUM_CORES, 4, number of cores (the arbiter and the ID width are sized for 4)
- RESULT_W, 16, width of one core result
- FIFO_DEPTH, 4, completion FIFO entries (power of two)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- execute_core  in  NUM_CORES  one-hot target core from scheduler
- dispatch_task  in  1  dispatch strobe qualifying execute_core
- core_done  in  NUM_CORES  per-core done level, held until acked
- core_result  in  NUM_CORES*RESULT_W  per-core result; core i at bits [i*RESULT_W +: RESULT_W], stable while done high
- core_busy  out  NUM_CORES  registered busy flags, fed back to scheduler
- core_done_ack  out  NUM_CORES  registered one-cycle ack to the accepted core
- cpl_valid  out  1  completion available at FIFO head
- cpl_ready  in  1  consumer accepts head
- cpl_core  out  2  core index of head entry
- cpl_result  out  RESULT_W  result of head entry
- fifo_count  out  3  occupied entries, 0..FIFO_DEPTH
- protocol_err  out  1  registered one-cycle error pulse

## Operation
- Dispatch, evaluated every edge while dispatch_task=1:
  - Legal when execute_core is one-hot and the target's core_busy=0: that busy bit sets at the edge.
  - Illegal when execute_core is zero, multi-hot, or targets a busy core: busy is unchanged and protocol_err pulses next cycle.
- Eligible core i: core_done[i]=1, core_busy[i]=1 and core_done_ack[i]=0.
- core_done[i]=1 with core_busy[i]=0 and core_done_ack[i]=0 (spurious done): ignored, protocol_err pulses.
- Arbitration:
  - rr_ptr (2 bits, reset 0) marks the search start.
  - Grant goes to the first eligible index at or after rr_ptr, wrapping modulo 4.
  - A grant happens only if fifo_count < FIFO_DEPTH.
  - At most one grant per cycle.
- On grant to core g, at the edge:
  - push {g, core_result[g]} into the FIFO;
  - clear core_busy[g];
  - set core_done_ack[g] for exactly one cycle;
  - rr_ptr <= (g+1) mod 4.
- Core contract: the core drops done after seeing the ack. The done level still high during the ack cycle is neither eligible nor an error.
- Dispatch to core g in the same cycle as its grant: busy is still 1, so this is illegal. Error pulses; busy ends at 0.
- FIFO:
  - cpl_valid = (fifo_count != 0); cpl_core and cpl_result come from the head.
  - Pop when cpl_valid & cpl_ready.
  - Push and pop in the same cycle: count unchanged. Full with a pop: no push that cycle; the grant waits one cycle (no bypass).
  - Empty head outputs hold their last value (0 after reset).
- Reset asserted mid-operation: all state clears immediately and buffered completions are lost. Cores must be reset alongside.

## Timing
- Reset values: core_busy=0, core_done_ack=0, cpl_valid=0, cpl_core=0, cpl_result=0, fifo_count=0, protocol_err=0, rr_ptr=0.
- Dispatch at edge T: core_busy visible from T.
- Done eligible in the cycle before edge T:
  - push and busy clear at T;
  - ack high T..T+1;
  - cpl_valid high from T when the FIFO was empty (1-cycle done→valid latency).
- Sustained throughput: one completion accepted per cycle and one popped per cycle.
- protocol_err: asserted for one cycle after the offending edge; no other state effect.

## Test plan
- Reset; dispatch to core 2 -> core_busy=4'b0100. Core 2 done, result 16'hBEEF -> ack[2] for 1 cycle; cpl_valid with cpl_core=2, cpl_result=16'hBEEF; busy returns to 0.
- All 4 cores busy; all done in the same cycle; rr_ptr=0; cpl_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; fifo_count ≤2.
- cpl_ready=0; 4 completions fill the FIFO (count=4); a 5th core raises done -> no ack while full. Raise cpl_ready -> 5th accepted the cycle after the first pop.
- Dispatch with execute_core=4'b0011, and dispatch to an already-busy core 1 -> protocol_err pulses twice; core_busy unchanged.
- Done on idle core 3 -> protocol_err=1 for one cycle, no ack, no FIFO push.
- Reset driven low with 3 entries buffered and 2 cores busy -> all outputs return to reset values immediately, fifo_count=0.

Source files
------------

// File: rtl/task_completion_collector.sv
// Per-core busy tracking plus round-robin collection of core completions into a small FIFO.
// Latency: done to cpl_valid is 1 cycle. Backpressure: a full FIFO holds off grants, and cores keep done high until they are acked.
module task_completion_collector #(
    parameter int NUM_CORES  = 4,
    parameter int RESULT_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          execute_core,
    input  logic                          dispatch_task,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES*RESULT_W-1:0] core_result,
    output logic [NUM_CORES-1:0]          core_busy,
    output logic [NUM_CORES-1:0]          core_done_ack,
    output logic                          cpl_valid,
    input  logic                          cpl_ready,
    output logic [1:0]                    cpl_core,
    output logic [RESULT_W-1:0]           cpl_result,
    output logic [2:0]                    fifo_count,
    output logic                          protocol_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]          core;
        logic [RESULT_W-1:0] result;
    } cpl_t;

    cpl_t                 mem [FIFO_DEPTH];
    cpl_t                 head;
    cpl_t                 last_q;
    cpl_t                 push_dat;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [1:0]           rr_ptr;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] busy_nxt;
    logic [NUM_CORES-1:0] ack_nxt;
    logic                 spurious_err;
    logic                 disp_legal;
    logic                 disp_err;
    logic                 fifo_full;
    logic                 gnt_vld;
    logic [1:0]           gnt_idx;
    logic [1:0]           scan_idx;
    logic                 pop;

    assign head       = mem[rd_ptr];
    assign cpl_valid  = (fifo_count != 3'd0);
    // An empty FIFO shows the last popped entry rather than stale storage.
    assign cpl_core   = cpl_valid ? head.core   : last_q.core;
    assign cpl_result = cpl_valid ? head.result : last_q.result;
    assign pop        = cpl_valid && cpl_ready;

    always_comb begin
        eligible     = core_done & core_busy & ~core_done_ack;
        spurious_err = |(core_done & ~core_busy & ~core_done_ack);
        disp_legal   = dispatch_task && $onehot(execute_core) &&
                       ((execute_core & core_busy) == '0);
        disp_err     = dispatch_task && !disp_legal;
        fifo_full    = (fifo_count == 3'(FIFO_DEPTH));

        gnt_vld  = 1'b0;
        gnt_idx  = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!gnt_vld && !fifo_full && eligible[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end

        push_dat.core   = gnt_idx;
        push_dat.result = core_result[int'(gnt_idx)*RESULT_W +: RESULT_W];

        // A dispatch that collides with a grant sees busy=1, so it is rejected and busy ends clear.
        busy_nxt = core_busy;
        ack_nxt  = '0;
        if (gnt_vld) begin
            busy_nxt[gnt_idx] = 1'b0;
            ack_nxt[gnt_idx]  = 1'b1;
        end
        if (disp_legal) begin
            busy_nxt = busy_nxt | execute_core;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_busy     <= '0;
            core_done_ack <= '0;
            protocol_err  <= 1'b0;
            rr_ptr        <= 2'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= 3'd0;
            last_q        <= '0;
        end else begin
            core_busy     <= busy_nxt;
            core_done_ack <= ack_nxt;
            protocol_err  <= disp_err || spurious_err;
            if (gnt_vld) begin
                rr_ptr <= gnt_idx + 2'd1;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= head;
            end
            fifo_count <= fifo_count + 3'(gnt_vld) - 3'(pop);
        end
    end

endmodule

// File: tb/tb_task_completion_collector.sv
// Directed bench for task_completion_collector; inputs change and outputs are sampled on the falling edge.
module tb_task_completion_collector;

    logic        clk;
    logic        reset;
    logic [3:0]  execute_core;
    logic        dispatch_task;
    logic [3:0]  core_done;
    logic [63:0] core_result;
    logic [3:0]  core_busy;
    logic [3:0]  core_done_ack;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [1:0]  cpl_core;
    logic [15:0] cpl_result;
    logic [2:0]  fifo_count;
    logic        protocol_err;

    int total = 0;
    int bad   = 0;
    logic [3:0] ack_prev;

    task_completion_collector #(.NUM_CORES(4), .RESULT_W(16), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .execute_core  (execute_core),
        .dispatch_task (dispatch_task),
        .core_done     (core_done),
        .core_result   (core_result),
        .core_busy     (core_busy),
        .core_done_ack (core_done_ack),
        .cpl_valid     (cpl_valid),
        .cpl_ready     (cpl_ready),
        .cpl_core      (cpl_core),
        .cpl_result    (cpl_result),
        .fifo_count    (fifo_count),
        .protocol_err  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; cores drop done one edge after they saw their ack.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        core_done = core_done & ~ack_prev;
        ack_prev  = core_done_ack;
    endtask

    task automatic dispatch(input logic [3:0] tgt);
        execute_core  = tgt;
        dispatch_task = 1'b1;
        step();
        dispatch_task = 1'b0;
        execute_core  = 4'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        execute_core  = 4'b0;
        dispatch_task = 1'b0;
        core_done     = 4'b0;
        core_result   = 64'b0;
        cpl_ready     = 1'b0;
        ack_prev      = 4'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  32'(core_busy),     32'h0);
        chk({tag, "_ack"},   32'(core_done_ack), 32'h0);
        chk({tag, "_vld"},   32'(cpl_valid),     32'h0);
        chk({tag, "_core"},  32'(cpl_core),      32'h0);
        chk({tag, "_res"},   32'(cpl_result),    32'h0);
        chk({tag, "_cnt"},   32'(fifo_count),    32'h0);
        chk({tag, "_err"},   32'(protocol_err),  32'h0);
    endtask

    logic [1:0]  exp_core [4];
    logic [15:0] exp_res  [4];

    initial begin
        reset = 1'b0;
        execute_core = 4'b0; dispatch_task = 1'b0; core_done = 4'b0;
        core_result = 64'b0; cpl_ready = 1'b0; ack_prev = 4'b0;
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        do_reset();

        // Single dispatch/complete on core 2
        dispatch(4'b0100);
        chk("t1_busy", 32'(core_busy), 32'h4);
        chk("t1_err0", 32'(protocol_err), 32'h0);
        core_result[2*16 +: 16] = 16'hBEEF;
        core_done[2] = 1'b1;
        step();
        chk("t1_ack",  32'(core_done_ack), 32'h4);
        chk("t1_vld",  32'(cpl_valid), 32'h1);
        chk("t1_core", 32'(cpl_core), 32'h2);
        chk("t1_res",  32'(cpl_result), 32'hBEEF);
        chk("t1_busy0", 32'(core_busy), 32'h0);
        chk("t1_cnt",  32'(fifo_count), 32'h1);
        step();
        chk("t1_ack_off", 32'(core_done_ack), 32'h0);
        chk("t1_err_ackcyc", 32'(protocol_err), 32'h0);
        step();
        chk("t1_err_after", 32'(protocol_err), 32'h0);
        cpl_ready = 1'b1;
        step();
        cpl_ready = 1'b0;
        chk("t1_pop_vld", 32'(cpl_valid), 32'h0);
        chk("t1_hold_core", 32'(cpl_core), 32'h2);
        chk("t1_hold_res", 32'(cpl_result), 32'hBEEF);

        // All four cores done together, round-robin from 0, consumer always ready
        do_reset();
        for (int i = 0; i < 4; i++) dispatch(4'(1 << i));
        chk("t2_busy", 32'(core_busy), 32'hF);
        for (int i = 0; i < 4; i++) core_result[i*16 +: 16] = 16'h1000 + 16'(i);
        core_done = 4'hF;
        cpl_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_ack%0d", k),  32'(core_done_ack), 32'(1) << k);
            chk($sformatf("t2_core%0d", k), 32'(cpl_core), 32'(k));
            chk($sformatf("t2_res%0d", k),  32'(cpl_result), 32'h1000 + 32'(k));
            chk($sformatf("t2_cnt%0d", k),  32'(fifo_count <= 3'd2), 32'h1);
            chk($sformatf("t2_err%0d", k),  32'(protocol_err), 32'h0);
        end
        step();
        chk("t2_empty", 32'(cpl_valid), 32'h0);
        chk("t2_busy0", 32'(core_busy), 32'h0);
        cpl_ready = 1'b0;

        // Fill the FIFO, hold off a fifth completion, release it after one pop
        do_reset();
        for (int i = 0; i < 4; i++) dispatch(4'(1 << i));
        for (int i = 0; i < 4; i++) core_result[i*16 +: 16] = 16'h2000 + 16'(i);
        core_done = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_ack%0d", k), 32'(core_done_ack), 32'(1) << k);
            chk($sformatf("t3_cnt%0d", k), 32'(fifo_count), 32'(k + 1));
        end
        step();
        chk("t3_full", 32'(fifo_count), 32'h4);
        dispatch(4'b0001);
        chk("t3_redisp", 32'(core_busy), 32'h1);
        core_result[0 +: 16] = 16'h2AAA;
        core_done[0] = 1'b1;
        step();
        chk("t3_noack_a", 32'(core_done_ack), 32'h0);
        chk("t3_cnt_a", 32'(fifo_count), 32'h4);
        step();
        chk("t3_noack_b", 32'(core_done_ack), 32'h0);
        cpl_ready = 1'b1;
        step();
        cpl_ready = 1'b0;
        chk("t3_pop_noack", 32'(core_done_ack), 32'h0);
        chk("t3_pop_cnt", 32'(fifo_count), 32'h3);
        step();
        chk("t3_late_ack", 32'(core_done_ack), 32'h1);
        chk("t3_late_cnt", 32'(fifo_count), 32'h4);
        chk("t3_late_busy", 32'(core_busy), 32'h0);
        exp_core = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_res  = '{16'h2001, 16'h2002, 16'h2003, 16'h2AAA};
        cpl_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_dcore%0d", k), 32'(cpl_core), 32'(exp_core[k]));
            chk($sformatf("t3_dres%0d", k),  32'(cpl_result), 32'(exp_res[k]));
            step();
        end
        cpl_ready = 1'b0;
        chk("t3_drained", 32'(fifo_count), 32'h0);
        chk("t3_hold", 32'(cpl_result), 32'h2AAA);

        // Illegal dispatches
        do_reset();
        dispatch(4'b0011);
        chk("t4_multi_err", 32'(protocol_err), 32'h1);
        chk("t4_multi_busy", 32'(core_busy), 32'h0);
        step();
        chk("t4_err_clr", 32'(protocol_err), 32'h0);
        dispatch(4'b0000);
        chk("t4_zero_err", 32'(protocol_err), 32'h1);
        dispatch(4'b0010);
        chk("t4_legal_err", 32'(protocol_err), 32'h0);
        chk("t4_legal_busy", 32'(core_busy), 32'h2);
        dispatch(4'b0010);
        chk("t4_busy_err", 32'(protocol_err), 32'h1);
        chk("t4_busy_keep", 32'(core_busy), 32'h2);
        step();
        chk("t4_err_clr2", 32'(protocol_err), 32'h0);
        core_result[1*16 +: 16] = 16'h5A5A;
        core_done[1] = 1'b1;
        dispatch(4'b0010);
        chk("t4_coll_err", 32'(protocol_err), 32'h1);
        chk("t4_coll_busy", 32'(core_busy), 32'h0);
        chk("t4_coll_ack", 32'(core_done_ack), 32'h2);
        chk("t4_coll_res", 32'(cpl_result), 32'h5A5A);

        // Spurious done on idle core 3
        do_reset();
        core_done[3] = 1'b1;
        step();
        core_done[3] = 1'b0;
        chk("t5_err", 32'(protocol_err), 32'h1);
        chk("t5_ack", 32'(core_done_ack), 32'h0);
        chk("t5_cnt", 32'(fifo_count), 32'h0);
        step();
        chk("t5_err_clr", 32'(protocol_err), 32'h0);

        // Reset in the middle of activity
        do_reset();
        for (int i = 0; i < 3; i++) dispatch(4'(1 << i));
        for (int i = 0; i < 3; i++) core_result[i*16 +: 16] = 16'h3000 + 16'(i);
        core_done = 4'b0111;
        for (int k = 0; k < 3; k++) step();
        dispatch(4'b1000);
        dispatch(4'b0001);
        chk("t6_pre_cnt", 32'(fifo_count), 32'h3);
        chk("t6_pre_busy", 32'(core_busy), 32'h9);
        chk("t6_pre_core", 32'(cpl_core), 32'h0);
        chk("t6_pre_res", 32'(cpl_result), 32'h3000);
        reset = 1'b0;
        #1;
        chk_reset_state("t6");
        reset = 1'b1;
        step();
        chk("t6_post_cnt", 32'(fifo_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
